// File: rtl/phyretrain_pkg.sv
// Shared PHYRETRAIN definitions used by both the TX and RX stages:
// sideband message codes, one-hot retrain encodings and FSM states.
package phyretrain_pkg;

  localparam int unsigned MSG_PHYRETRAIN_START_REQ  = 1;
  localparam int unsigned MSG_PHYRETRAIN_START_RESP = 2;

  localparam logic [2:0] ENC_TXSELFCAL = 3'b001;
  localparam logic [2:0] ENC_SPEEDIDLE = 3'b010;
  localparam logic [2:0] ENC_REPAIR    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REQ,
    ST_SEND_RESP,
    ST_DONE,
    ST_TIMEOUT
  } phyretrain_state_e;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
  endfunction

endpackage

// File: rtl/phyretrain_encoding_resolver.sv
// Combinational resolve of local/partner retrain encodings with one-hot check.
// Priority SPEEDIDLE > REPAIR > TXSELFCAL; malformed vectors count as SPEEDIDLE.
module phyretrain_encoding_resolver
  import phyretrain_pkg::*;
(
  input  logic [2:0] i_local_info,
  input  logic [2:0] i_partner_info,
  output logic [2:0] o_resolved,
  output logic       o_partner_err
);

  logic       w_local_ok;
  logic       w_partner_ok;
  logic [2:0] w_merged;

  assign w_local_ok    = is_onehot3(i_local_info);
  assign w_partner_ok  = is_onehot3(i_partner_info);
  assign o_partner_err = ~w_partner_ok;
  assign w_merged      = (w_local_ok   ? i_local_info   : ENC_SPEEDIDLE) |
                         (w_partner_ok ? i_partner_info : ENC_SPEEDIDLE);

  always_comb begin
    o_resolved = ENC_TXSELFCAL;
    if ((w_merged & ENC_SPEEDIDLE) != 3'b000)
      o_resolved = ENC_SPEEDIDLE;
    else if ((w_merged & ENC_REPAIR) != 3'b000)
      o_resolved = ENC_REPAIR;
  end

endmodule

// File: rtl/rx_phyretrain_resp.sv
// RX PHYRETRAIN responder: waits for START_REQ, resolves the retrain encoding,
// answers with START_RESP and reports completion/timeout to the LTSM.
module rx_phyretrain_resp
  import phyretrain_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_phyretrain_en,
  input  logic [2:0]              i_local_msg_info,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_rx_msg_valid,
  input  logic [2:0]              i_rx_msg_info,
  input  logic                    i_falling_edge_busy,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
  output logic [2:0]              o_msg_info_rx,
  output logic                    o_valid_rx,
  output logic                    o_phyretrain_end_rx,
  output logic [2:0]              o_resolved_state,
  output logic                    o_encoding_error,
  output logic                    o_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  phyretrain_state_e r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic       w_req_seen;
  logic       w_capture;
  logic [2:0] w_resolved;
  logic       w_partner_err;

  phyretrain_encoding_resolver u_resolver (
    .i_local_info   (i_local_msg_info),
    .i_partner_info (i_rx_msg_info),
    .o_resolved     (w_resolved),
    .o_partner_err  (w_partner_err)
  );

  assign w_req_seen = i_rx_msg_valid &&
                      (i_decoded_SB_msg == SB_MSG_WIDTH'(MSG_PHYRETRAIN_START_REQ));
  // A REQ is only captured while listening; it beats timer expiry.
  assign w_capture  = w_req_seen &&
                      ((r_state == ST_IDLE) || (r_state == ST_WAIT_REQ));

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_phyretrain_en) begin
      r_state             <= ST_IDLE;
      r_cnt               <= '0;
      o_encoded_SB_msg_rx <= '0;
      o_msg_info_rx       <= '0;
      o_valid_rx          <= 1'b0;
      o_phyretrain_end_rx <= 1'b0;
      o_resolved_state    <= '0;
      o_encoding_error    <= 1'b0;
      o_timeout           <= 1'b0;
    end else if (w_capture) begin
      r_state             <= ST_SEND_RESP;
      o_valid_rx          <= 1'b1;
      o_encoded_SB_msg_rx <= SB_MSG_WIDTH'(MSG_PHYRETRAIN_START_RESP);
      o_msg_info_rx       <= w_resolved;
      o_resolved_state    <= w_resolved;
      o_encoding_error    <= w_partner_err;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_WAIT_REQ;
          r_cnt   <= '0;
        end
        ST_WAIT_REQ: begin
          if (r_cnt == CNT_LAST) begin
            r_state   <= ST_TIMEOUT;
            o_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SEND_RESP: begin
          if (i_falling_edge_busy) begin
            r_state             <= ST_DONE;
            o_valid_rx          <= 1'b0;
            o_phyretrain_end_rx <= 1'b1;
          end
        end
        ST_DONE, ST_TIMEOUT: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_phyretrain_resp.sv
// Bench for rx_phyretrain_resp: directed literal checks plus randomized
// stimulus compared every cycle against a phase-level behavioural model.
module tb_rx_phyretrain_resp;

  localparam int W = 4;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [2:0]   local_info = 3'b001;
  logic [W-1:0] dec_msg = '0;
  logic         msg_valid = 1'b0;
  logic [2:0]   rx_info = 3'b000;
  logic         busy = 1'b0;

  logic [W-1:0] o_msg;
  logic [2:0]   o_info;
  logic         o_valid;
  logic         o_end;
  logic [2:0]   o_res;
  logic         o_err;
  logic         o_to;

  int checks = 0;
  int failures = 0;

  rx_phyretrain_resp #(.SB_MSG_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_phyretrain_en     (en),
    .i_local_msg_info    (local_info),
    .i_decoded_SB_msg    (dec_msg),
    .i_rx_msg_valid      (msg_valid),
    .i_rx_msg_info       (rx_info),
    .i_falling_edge_busy (busy),
    .o_encoded_SB_msg_rx (o_msg),
    .o_msg_info_rx       (o_info),
    .o_valid_rx          (o_valid),
    .o_phyretrain_end_rx (o_end),
    .o_resolved_state    (o_res),
    .o_encoding_error    (o_err),
    .o_timeout           (o_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_WAIT = 1, P_RESP = 2, P_DONE = 3, P_TO = 4;
  int       m_phase = P_IDLE;
  int       m_age = 0;
  logic [2:0] m_res = '0;
  logic     m_err = 1'b0;
  bit       m_started = 0;

  function automatic logic [2:0] model_resolve(input logic [2:0] l, input logic [2:0] p);
    logic [2:0] lv, pv, u;
    lv = ($countones(l) == 1) ? l : 3'b010;
    pv = ($countones(p) == 1) ? p : 3'b010;
    u  = lv | pv;
    if (u[1]) return 3'b010;
    if (u[2]) return 3'b100;
    return 3'b001;
  endfunction

  always @(posedge clk) begin
    logic req;
    m_started = 1;
    req = msg_valid && (dec_msg == W'(1));
    if (rst || !en) begin
      m_phase = P_IDLE;
    end else if (req && (m_phase == P_IDLE || m_phase == P_WAIT)) begin
      m_phase = P_RESP;
      m_res   = model_resolve(local_info, rx_info);
      m_err   = ($countones(rx_info) != 1);
    end else if (m_phase == P_IDLE) begin
      m_phase = P_WAIT;
      m_age   = 0;
    end else if (m_phase == P_WAIT) begin
      m_age++;
      if (m_age == T) m_phase = P_TO;
    end else if (m_phase == P_RESP && busy) begin
      m_phase = P_DONE;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      logic captured;
      captured = (m_phase == P_RESP) || (m_phase == P_DONE);
      chk("valid", int'(o_valid), int'(m_phase == P_RESP));
      chk("end", int'(o_end), int'(m_phase == P_DONE));
      chk("timeout", int'(o_to), int'(m_phase == P_TO));
      chk("resolved", int'(o_res), captured ? int'(m_res) : 0);
      chk("enc_err", int'(o_err), captured ? int'(m_err) : 0);
      if (m_phase == P_RESP) begin
        chk("msg_code", int'(o_msg), 2);
        chk("msg_info", int'(o_info), int'(m_res));
      end
      if (m_phase == P_IDLE) begin
        chk("idle_msg", int'(o_msg), 0);
        chk("idle_info", int'(o_info), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic quiet();
    msg_valid = 1'b0; dec_msg = '0; rx_info = 3'b000; busy = 1'b0;
  endtask

  task automatic send_req(input logic [2:0] info);
    msg_valid = 1'b1; dec_msg = W'(1); rx_info = info;
  endtask

  task automatic abort();
    quiet(); en = 1'b0; tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_res", int'(o_res), 0);
    chk("rst_to", int'(o_to), 0);
    rst = 1'b0;

    // Basic handshake: local 001, partner 001, REQ after a WAIT_REQ dwell.
    en = 1'b1; local_info = 3'b001; tick();
    tick();
    send_req(3'b001); tick();
    quiet();
    chk("t1_valid", int'(o_valid), 1);
    chk("t1_msg", int'(o_msg), 2);
    chk("t1_info", int'(o_info), 1);
    tick(); tick();
    busy = 1'b1; tick();
    busy = 1'b0;
    chk("t1_valid_off", int'(o_valid), 0);
    chk("t1_end", int'(o_end), 1);
    chk("t1_res", int'(o_res), 1);
    abort();
    chk("t1_abort_end", int'(o_end), 0);

    // REQ coincident with enable: local 100 vs partner 010 -> 010, no dwell.
    en = 1'b1; local_info = 3'b100; send_req(3'b010); tick();
    quiet();
    chk("t2_valid", int'(o_valid), 1);
    chk("t2_info", int'(o_info), 2);
    chk("t2_res", int'(o_res), 2);
    // Abort during SEND_RESP, then fresh resolution 001 vs 100 -> 100.
    abort();
    chk("t2_abort_valid", int'(o_valid), 0);
    chk("t2_abort_res", int'(o_res), 0);
    en = 1'b1; local_info = 3'b001; send_req(3'b100); tick();
    quiet();
    chk("t3_res", int'(o_res), 4);
    chk("t3_err", int'(o_err), 0);
    abort();

    // Malformed partner vector.
    en = 1'b1; local_info = 3'b100; send_req(3'b011); tick();
    quiet();
    chk("t4_err", int'(o_err), 1);
    chk("t4_res", int'(o_res), 2);
    abort();

    // Timeout: WAIT_REQ entered at first edge with en high.
    en = 1'b1; tick();
    repeat (T - 1) tick();
    chk("t5_to_early", int'(o_to), 0);
    tick();
    chk("t5_to", int'(o_to), 1);
    chk("t5_valid", int'(o_valid), 0);
    abort();

    // REQ on the expiry cycle wins over the timeout.
    en = 1'b1; tick();
    repeat (T - 1) tick();
    send_req(3'b001); local_info = 3'b001; tick();
    quiet();
    chk("t6_to", int'(o_to), 0);
    chk("t6_valid", int'(o_valid), 1);
    abort();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      en         = ($urandom_range(0, 24) != 0);
      msg_valid  = ($urandom_range(0, 7) == 0);
      dec_msg    = ($urandom_range(0, 1) == 0) ? W'(1) : W'($urandom_range(0, 3));
      rx_info    = 3'($urandom_range(0, 7));
      busy       = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0)
        local_info = 3'($urandom_range(0, 7));
      else
        local_info = 3'b001 << $urandom_range(0, 2);
      tick();
    end
    rst = 1'b0; quiet(); en = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
